seq_det_scheduler: RTL and testbench
====================================

// Module: seq_det_scheduler
// PURPOSE
//  Shares one serial Mealy pattern-detector core among NREQ requesters. Each requester offers a WORD_W-bit word;
//  a round-robin arbiter grants one word at a time and shifts it MSB-first through the core.
//  The block counts overlapping PATTERN hits and reports the count with the requester id.
//  Sits between the parallel-word producers and the shared seq_det_core.
// PARAMETERS
//  NREQ    4        number of requesters (>=2)
//  WORD_W  8        bits per word
//  PAT_W   4        pattern length (<= WORD_W)
//  PATTERN 4'b1001  bit sequence detected, MSB arrives first; overlapping matches count
//  CNT_W   4        match counter width; counter saturates at 2**CNT_W-1
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              synchronous, active-low reset
//  req        in   NREQ           request per requester; hold high with stable word until gnt
//  word       in   NREQ*WORD_W    requester i word at [i*WORD_W +: WORD_W]
//  gnt        out  NREQ           one-hot, one-cycle pulse; word[idx] captured at this clock edge
//  busy       out  1              high in LOAD/SHIFT/REPORT
//  done       out  1              one-cycle pulse; result valid
//  done_id    out  $clog2(NREQ)   requester index of the finished word (held until next done)
//  match_cnt  out  CNT_W          hit count of the finished word (held until next done)
//  hit        out  1              per-bit Mealy hit from the core (debug / observability)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, gnt=0, busy=0, done=0, done_id=0, match_cnt=0, hit=0.
//    Round-robin pointer is set to NREQ-1, so req[0] has top priority first. Core state is cleared.
//  - Reset mid-operation aborts the word: no done and no result. The aborted requester is not re-granted automatically;
//    it re-requests by keeping req high.
//  - FSM (states in package):
//    IDLE: if |req, select the first set req scanning ptr+1, ptr+2, ... (mod NREQ); latch idx; go to LOAD.
//          Otherwise stay in IDLE.
//    LOAD: gnt[idx]=1; shreg<=word[idx]; bitcnt<=0; cnt<=0; core cleared; go to SHIFT.
//    SHIFT: core bit_in=shreg[MSB], valid=1; shreg<<=1; bitcnt++.
//           If hit, cnt<=sat(cnt+1): cnt stays at 2**CNT_W-1 once reached.
//           After bit WORD_W-1 has been shifted, go to REPORT.
//    REPORT: done=1; done_id<=idx; match_cnt<=final cnt, including a hit on the last bit; ptr<=idx; go to IDLE.
//  - Latency: req seen in IDLE at cycle 0 -> gnt in cycle 1 -> done in cycle WORD_W+2.
//    Minimum spacing between two grants is WORD_W+3 cycles.
//  - Requests arriving while busy wait; req sampled only in IDLE. A req still high after its gnt is a new request
//    and competes in round-robin (others first).
//  - The core is cleared per word: no pattern spans two words. hit=0 outside SHIFT.
//  - Arbiter wrap-around: ptr=NREQ-1 scans 0 first. A single active requester is re-granted back-to-back.
//  - gnt is one-hot or zero at all times; done and gnt are never high in the same cycle.
// STRUCTURE
//  - Package seq_ctrl_pkg: FSM state encoding (IDLE, LOAD, SHIFT, REPORT), default PATTERN/PAT_W constants,
//    sat_inc function.
//  - Sub-module seq_det_core: Mealy overlapping detector.
//    Ports: clk, reset, clear, valid, bit_in, hit (combinational on bit_in and state).
//    State is the longest matched prefix (KMP-style next-state table built from PATTERN).
//  - Top level: round-robin arbiter, shift register, bit counter, saturating counter, control FSM.
// TESTING
//  1. Defaults. req[0]=1, word0=8'h92 (1001_0010) at cycle 0.
//     -> gnt=4'b0001 cycle 1; hits after bits 3 and 6; done cycle 10, done_id=0, match_cnt=2.
//  2. After reset, req=4'b1111 held with each requester dropping req after its gnt.
//     -> grants 0,1,2,3 in order, each 11 cycles apart, four done pulses with ids 0..3.
//  3. Words 8'h00 -> cnt 0; 8'hFF -> cnt 0; 8'h99 (1001_1001) -> cnt 2; 8'h09 -> cnt 1 (hit on last bit).
//  4. reset=0 for one cycle during SHIFT bit 4 of req[1].
//     -> next cycle IDLE, busy=0, done=0, match_cnt=0, no done for that word.
//     req[1] still high -> regranted and completes.
//  5. req[2] and req[3] held high continuously. -> grant order 2,3,2,3,...; never two consecutive grants to the same id.
//  6. WORD_W=16, CNT_W=2, word=16'h9249 (5 overlapping matches). -> match_cnt saturates at 3, no wrap to 0.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared FSM states, default pattern and saturating increment
package seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, REPORT} state_t;
  localparam int DEF_PAT_W = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1001;
  function automatic int sat_inc(input int v, input int mx);
    return v >= mx ? mx : v + 1;
  endfunction
endpackage

// File: rtl/seq_det_core.sv
// seq_det_core: overlapping Mealy detector of PATTERN, MSB first, state is longest matched prefix
module seq_det_core import seq_ctrl_pkg::*; #(
  parameter int PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic valid,
  input  logic bit_in,
  output logic hit
);
  localparam int SW = PAT_W > 1 ? $clog2(PAT_W) : 1;
  logic [SW-1:0] st;
  function automatic logic pbit(input int p);
    logic [PAT_W-1:0] t;
    t = PATTERN >> (PAT_W - 1 - p);
    return t[0];
  endfunction
  function automatic int nxt(input int s, input logic b);
    int best;
    logic ok, xb;
    best = 0;
    for (int k = 1; k < PAT_W; k++) begin
      ok = k <= s + 1;
      for (int i = 0; i < PAT_W; i++) begin
        xb = (s + 1 - k + i == s) ? b : pbit(s + 1 - k + i);
        if (ok && i < k && xb != pbit(i)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction
  always_comb hit = valid && int'(st) == PAT_W - 1 && bit_in == PATTERN[0];
  always_ff @(posedge clk)
    st <= (!reset || clear) ? '0 : valid ? SW'(nxt(int'(st), bit_in)) : st;
endmodule

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: round-robin sharing of one serial pattern detector among NREQ word requesters
module seq_det_scheduler import seq_ctrl_pkg::*; #(
  parameter int NREQ = 4,
  parameter int WORD_W = 8,
  parameter int PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WORD_W-1:0]   word,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     hit
);
  localparam int IW = $clog2(NREQ);
  localparam int BW = WORD_W > 1 ? $clog2(WORD_W) : 1;
  state_t st;
  logic [IW-1:0] idx, ptr, sel;
  logic [WORD_W-1:0] shreg;
  logic [BW-1:0] bitcnt;
  logic [CNT_W-1:0] cnt, nc;
  seq_det_core #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_core (
    .clk,
    .reset,
    .clear(st == LOAD),
    .valid(st == SHIFT),
    .bit_in(shreg[WORD_W-1]),
    .hit
  );
  always_comb begin
    sel = '0;
    for (int k = NREQ; k >= 1; k--)
      if (req[IW'((int'(ptr) + k) % NREQ)]) sel = IW'((int'(ptr) + k) % NREQ);
  end
  always_comb nc = hit ? CNT_W'(sat_inc(int'(cnt), (1 << CNT_W) - 1)) : cnt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= IDLE;
      gnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      done_id <= '0;
      match_cnt <= '0;
      ptr <= IW'(NREQ - 1);
      idx <= '0;
      shreg <= '0;
      bitcnt <= '0;
      cnt <= '0;
    end else begin
      gnt <= '0;
      done <= 1'b0;
      case (st)
        IDLE: if (|req) begin
          idx <= sel;
          gnt <= NREQ'(1) << sel;
          busy <= 1'b1;
          st <= LOAD;
        end
        LOAD: begin
          shreg <= word[int'(idx)*WORD_W +: WORD_W];
          bitcnt <= '0;
          cnt <= '0;
          st <= SHIFT;
        end
        SHIFT: begin
          shreg <= shreg << 1;
          bitcnt <= bitcnt + 1'b1;
          cnt <= nc;
          if (bitcnt == BW'(WORD_W - 1)) begin
            done <= 1'b1;
            done_id <= idx;
            match_cnt <= nc;
            st <= REPORT;
          end
        end
        default: begin
          ptr <= idx;
          busy <= 1'b0;
          st <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb_seq_det_scheduler: scoreboard bench with behavioural arbiter/detector model
module tb_seq_det_scheduler;
  localparam int NREQ = 4;
  localparam int WORD_W = 8;
  localparam int CNT_W = 4;
  localparam int PAT_W = 4;
  localparam logic [3:0] PATTERN = 4'b1001;
  typedef struct { int cyc; int id; int cnt; } exp_t;
  logic clk = 0, reset = 0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*WORD_W-1:0] word = '0;
  logic [NREQ-1:0] gnt;
  logic busy, done, hit;
  logic [1:0] done_id;
  logic [CNT_W-1:0] match_cnt;
  logic [1:0] req2 = '0, gnt2;
  logic [31:0] word2 = '0;
  logic busy2, done2, hit2;
  logic [0:0] done_id2;
  logic [1:0] match_cnt2;
  seq_det_scheduler #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .word(word), .gnt(gnt), .busy(busy),
    .done(done), .done_id(done_id), .match_cnt(match_cnt), .hit(hit)
  );
  seq_det_scheduler #(.NREQ(2), .WORD_W(16), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .word(word2), .gnt(gnt2), .busy(busy2),
    .done(done2), .done_id(done_id2), .match_cnt(match_cnt2), .hit(hit2)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_assert = 0, n_fail = 0;
  exp_t gq[$], dq[$];
  exp_t me;
  bit hit_exp[int];
  int busy_lo = 0, busy_hi = -1, free_c = 0, ptr = NREQ - 1, g_id = -1;
  bit pend[NREQ], keep[NREQ];
  logic [7:0] wrd[NREQ];
  int hold_until[NREQ];
  bit auto_on = 0, mon_on = 0, t5_on = 0;
  int hid = 0, hcnt = 0;
  logic [NREQ-1:0] last_gnt = '0;
  logic [7:0] picks[6] = '{8'h92, 8'h99, 8'h09, 8'h49, 8'h24, 8'h93};
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_assert++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask
  function automatic bit hits_at(input logic [31:0] w, input int ww, input int k);
    logic [31:0] t;
    t = w >> (ww - 1 - k);
    return k >= PAT_W - 1 && t[PAT_W-1:0] == PATTERN;
  endfunction
  function automatic int exp_cnt(input logic [31:0] w, input int ww, input int cw);
    int n;
    n = 0;
    for (int k = 0; k < ww; k++) n += int'(hits_at(w, ww, k));
    return n < (1 << cw) - 1 ? n : (1 << cw) - 1;
  endfunction
  task automatic step(input logic rst_v);
    int c, w, j;
    logic [NREQ-1:0] any;
    @(posedge clk);
    #2;
    c = cyc;
    reset = rst_v;
    g_id = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (auto_on && !pend[i] && c > hold_until[i] && $urandom_range(0, 3) == 0) begin
        pend[i] = 1;
        wrd[i] = $urandom_range(0, 1) ? 8'($urandom) : picks[$urandom_range(0, 5)];
      end
      req[i] = pend[i];
      word[i*WORD_W +: WORD_W] = wrd[i];
      any[i] = pend[i];
    end
    if (!rst_v) begin
      while (gq.size() > 0 && gq[$].cyc > c) void'(gq.pop_back());
      while (dq.size() > 0 && dq[$].cyc > c) void'(dq.pop_back());
      for (int k = c + 1; k <= c + WORD_W + 3; k++) if (hit_exp.exists(k)) hit_exp.delete(k);
      if (busy_hi > c) busy_hi = c;
      free_c = c + 1;
      ptr = NREQ - 1;
    end else if (c >= free_c && |any) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        j = (ptr + k) % NREQ;
        if (w < 0 && pend[j]) w = j;
      end
      gq.push_back(exp_t'{c + 1, w, 0});
      dq.push_back(exp_t'{c + WORD_W + 2, w, exp_cnt(32'(wrd[w]), WORD_W, CNT_W)});
      for (int k = 0; k < WORD_W; k++) if (hits_at(32'(wrd[w]), WORD_W, k)) hit_exp[c + 2 + k] = 1;
      busy_lo = c + 1;
      busy_hi = c + WORD_W + 2;
      free_c = c + WORD_W + 3;
      ptr = w;
      hold_until[w] = c + 1;
      g_id = w;
      pend[w] = auto_on ? ($urandom_range(0, 2) == 0) : keep[w];
    end
  endtask
  always @(negedge clk) begin
    if (mon_on) begin
      chk("gnt_onehot0", 64'($onehot0(gnt)), 1);
      chk("gnt_done_excl", 64'(done && |gnt), 0);
      chk("busy", busy, 64'(cyc >= busy_lo && cyc <= busy_hi));
      chk("hit", hit, hit_exp.exists(cyc) ? 1 : 0);
      if (|gnt) begin
        if (gq.size() == 0) chk("gnt_unexpected", gnt, 0);
        else begin
          me = gq.pop_front();
          chk("gnt_vec", gnt, 64'(1 << me.id));
          chk("gnt_cycle", cyc, me.cyc);
        end
        if (t5_on) chk("t5_alternate", 64'(gnt == last_gnt), 0);
        last_gnt = gnt;
      end
      if (done) begin
        if (dq.size() == 0) chk("done_unexpected", done, 0);
        else begin
          me = dq.pop_front();
          chk("done_id", done_id, me.id);
          chk("done_cnt", match_cnt, me.cnt);
          chk("done_cycle", cyc, me.cyc);
          hid = me.id;
          hcnt = me.cnt;
        end
      end else begin
        chk("held_id", done_id, hid);
        chk("held_cnt", match_cnt, hcnt);
      end
      if (!reset) begin
        hid = 0;
        hcnt = 0;
      end
    end
  end
  initial begin
    bit got;
    int hc;
    for (int i = 0; i < NREQ; i++) wrd[i] = '0;
    step(0);
    step(0);
    mon_on = 1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_hit", hit, 0);
    pend[0] = 1;
    wrd[0] = 8'h92;
    repeat (14) step(1);
    chk("t1_held_id", done_id, 0);
    chk("t1_held_cnt", match_cnt, 2);
    step(0);
    wrd = '{8'h00, 8'hFF, 8'h99, 8'h09};
    for (int i = 0; i < NREQ; i++) pend[i] = 1;
    repeat (4 * (WORD_W + 3) + 4) step(1);
    chk("t3_last_cnt", match_cnt, 1);
    pend[1] = 1;
    keep[1] = 1;
    wrd[1] = 8'h99;
    for (int t = 0; t < 30 && g_id != 1; t++) step(1);
    repeat (5) step(1);
    step(0);
    keep[1] = 0;
    step(1);
    chk("rst_abort_busy", busy, 0);
    chk("rst_abort_done", done, 0);
    chk("rst_abort_cnt", match_cnt, 0);
    repeat (14) step(1);
    pend[2] = 1;
    pend[3] = 1;
    keep[2] = 1;
    keep[3] = 1;
    wrd[2] = 8'h49;
    wrd[3] = 8'h24;
    t5_on = 1;
    repeat (70) step(1);
    keep[2] = 0;
    keep[3] = 0;
    repeat (25) step(1);
    t5_on = 0;
    auto_on = 1;
    repeat (900) step($urandom_range(0, 149) != 0);
    auto_on = 0;
    for (int i = 0; i < NREQ; i++) keep[i] = 0;
    repeat (NREQ * (WORD_W + 3) + 15) step(1);
    req2 = 2'b01;
    word2 = {16'h0000, 16'h9249};
    got = 0;
    hc = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      step(1);
      if (gnt2[0]) begin
        req2 = '0;
        chk("t6_busy", busy2, 1);
      end
      if (hit2) hc++;
      if (done2) begin
        got = 1;
        chk("t6_sat_cnt", match_cnt2, 3);
        chk("t6_id", done_id2, 0);
        chk("t6_hits", hc, 5);
      end
    end
    chk("t6_done_seen", got, 1);
    chk("gnt_missing", gq.size(), 0);
    chk("done_missing", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
